uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  Serial UART frame transmitter: the transmit end of the uart_rx link in uart_top.
//  Serialises 5..8 data bits LSB-first with start bit, optional parity, and 1 or 2 stop bits.
//  Runs on one system clock. An internal divider sets the bit period from `baud`.
//  Parity and stop conventions match uart_rx, so tx drives uart_rx.rx directly.
// PARAMETERS
//  DIV_W    17   width of baud divisor input (clk cycles per bit)
//  MIN_DIV  2    smallest legal divisor; smaller values are rejected with tx_err
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst          in   1      synchronous, active-low reset
//  tx_start     in   1      request; sampled only in IDLE
//  tx_data      in   8      payload; bits [length-1:0] sent, upper bits ignored
//  length       in   4      data bits per frame, legal 5..8
//  parity_type  in   1      1: parity bit = ^data (even); 0: parity bit = ~^data (odd)
//  parity_en    in   1      1: insert parity bit after data
//  stop2        in   1      1: two stop bits; 0: one
//  baud         in   DIV_W  clk cycles per bit
//  tx_break     in   1      break request (active only with UART_TX_BREAK_EN)
//  tx           out  1      serial line, idle high
//  tx_busy      out  1      high from acceptance until tx_done inclusive
//  tx_done      out  1      1-cycle pulse after last stop bit
//  tx_err       out  1      1-cycle pulse on rejected request
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, tx=1, tx_busy=0, tx_done=0, tx_err=0, counters=0.
//   Reset mid-frame aborts the frame immediately. tx returns high on the next cycle.
//  FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
//  IDLE: tx=1. If tx_start=1 and length in 5..8 and baud>=MIN_DIV, the block:
//   - latches tx_data, length, parity_type, parity_en, stop2 and baud into shadow registers;
//   - goes to START on that edge.
//   Changing inputs mid-frame has no effect.
//  If tx_start=1 with an illegal length or baud: tx_err=1 for one cycle, stay IDLE, tx stays 1.
//  Bit timing: each of START/DATA/PARITY/STOP* holds tx for exactly baud_q clk cycles.
//   cyc_cnt counts 0..baud_q-1. The state or bit advances when cyc_cnt==baud_q-1.
//  START: tx=0.
//  DATA: tx=data_q[bit_cnt], bit_cnt 0..len_q-1. Then go to PARITY if par_en_q, else STOP1.
//  PARITY: tx = parity over data_q[len_q-1:0] only, per parity_type_q.
//  STOP1: tx=1. Then go to STOP2 if stop2_q, else DONE.
//  STOP2: tx=1.
//  DONE: single cycle. tx=1, tx_done=1, tx_busy=1. Next state is IDLE.
//   tx_start during DONE is ignored; the next frame starts at the earliest 1 cycle later.
//  Latency: with the request accepted at edge N, tx falls after edge N.
//   Frame length F = 1 + len + par_en + 1 + stop2 bits.
//   tx_done is high in the cycle after F*baud_q cycles of serial output.
//  tx_busy = (state != IDLE). tx_done and tx_err never assert in the same cycle.
//  cyc_cnt is DIV_W bits wide and never wraps (compare before increment).
//   bit_cnt is 3 bits wide.
// CONFIGURATION
//  UART_TX_BREAK_EN defined:
//   - tx_break=1 in IDLE enters BREAK (tx=0, tx_busy=1) instead of starting a frame.
//     tx_break has priority over tx_start.
//   - BREAK is held while tx_break=1. It lasts at least F*baud_q cycles, counted from its own entry.
//   - It then exits via DONE (tx_done pulse). tx_break is ignored during a frame.
//  UART_TX_BREAK_EN undefined: tx_break is ignored. There is no BREAK state, and the FSM has 7 states.
// TESTING
//  1 Hold rst=0 for 3 cycles while driving tx_start=1.
//    -> tx=1, busy/done/err=0 throughout. No frame starts after rst=1 until tx_start is re-sampled.
//  2 baud=4, len=8, data=0xA5, par_en=1, type=1, stop2=0.
//    -> tx bits 0,1,0,1,0,0,1,0,1,0(par),1, each 4 clk. tx_done at cycle 45 after acceptance.
//  3 baud=3, len=5, data=0xFF, par_en=0, stop2=1.
//    -> bits 0,1,1,1,1,1,1,1 (8 bits, 24 clk). Upper data bits are not sent. done pulse follows.
//  4 len=9 or len=4, or baud=1, with tx_start.
//    -> tx_err 1-cycle pulse, tx stays 1, busy stays 0.
//  5 Loopback into uart_rx for len 5..8, both parities, stop2 0/1, random data.
//    -> rx_out equals data, rx_err=0 for every frame.
//  6 Drop rst mid-DATA (bit 3), then release.
//    -> tx=1 the next cycle, busy=0, no done. A new tx_start sends a clean full frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, 5..8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_frame #(
  parameter int DIV_W   = 17,
  parameter int MIN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [7:0]       tx_data,
  input  logic [3:0]       length,
  input  logic             parity_type,
  input  logic             parity_en,
  input  logic             stop2,
  input  logic [DIV_W-1:0] baud,
  input  logic             tx_break,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_err
);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE, S_BREAK
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
  } state_e;
`endif

  state_e           state_q;
  logic [7:0]       data_q;
  logic [3:0]       len_q;
  logic             ptype_q;
  logic             pen_q;
  logic             stop2_q;
  logic [DIV_W-1:0] baud_q;
  logic [DIV_W-1:0] cyc_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic             tx_q;
  logic             done_q;
  logic             err_q;

  logic             cyc_last_d;
  logic             bit_last_d;
  logic [2:0]       nxt_bit_d;
  logic [7:0]       data_mask_d;
  logic             par_bit_d;
  logic             req_ok_d;

  assign cyc_last_d  = (cyc_cnt_q == baud_q - DIV_W'(1));
  assign bit_last_d  = ({1'b0, bit_cnt_q} == len_q - 4'd1);
  assign nxt_bit_d   = bit_cnt_q + 3'd1;
  // Parity covers only the bits actually sent, never the ignored upper payload bits.
  assign data_mask_d = data_q & (8'hFF >> (4'd8 - len_q));
  assign par_bit_d   = ptype_q ? (^data_mask_d) : ~(^data_mask_d);
  assign req_ok_d    = (length >= 4'd5) && (length <= 4'd8) && (baud >= DIV_W'(MIN_DIV));

`ifdef UART_TX_BREAK_EN
  logic [3:0] brk_cnt_q;
  logic [3:0] frame_bits_d;
  assign frame_bits_d = 4'd2 + len_q + {3'b000, pen_q} + {3'b000, stop2_q};
`else
  logic unused_break;
  assign unused_break = tx_break;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      len_q     <= '0;
      ptype_q   <= 1'b0;
      pen_q     <= 1'b0;
      stop2_q   <= 1'b0;
      baud_q    <= '0;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q      <= 1'b1;
          cyc_cnt_q <= '0;
          bit_cnt_q <= '0;
`ifdef UART_TX_BREAK_EN
          if (tx_break) begin
            len_q     <= length;
            pen_q     <= parity_en;
            stop2_q   <= stop2;
            baud_q    <= (baud < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud;
            brk_cnt_q <= '0;
            tx_q      <= 1'b0;
            state_q   <= S_BREAK;
          end else
`endif
          if (tx_start) begin
            if (req_ok_d) begin
              data_q  <= tx_data;
              len_q   <= length;
              ptype_q <= parity_type;
              pen_q   <= parity_en;
              stop2_q <= stop2;
              baud_q  <= baud;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_START: begin
          if (cyc_last_d) begin
            cyc_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= data_q[0];
            state_q   <= S_DATA;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (cyc_last_d) begin
            cyc_cnt_q <= '0;
            if (bit_last_d) begin
              tx_q    <= pen_q ? par_bit_d : 1'b1;
              state_q <= pen_q ? S_PARITY : S_STOP1;
            end else begin
              bit_cnt_q <= nxt_bit_d;
              tx_q      <= data_q[nxt_bit_d];
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_q + DIV_W'(1);
          end
        end
        S_PARITY: begin
          if (cyc_last_d) begin
            cyc_cnt_q <= '0;
            tx_q      <= 1'b1;
            state_q   <= S_STOP1;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + DIV_W'(1);
          end
        end
        S_STOP1: begin
          tx_q <= 1'b1;
          if (cyc_last_d) begin
            cyc_cnt_q <= '0;
            state_q   <= stop2_q ? S_STOP2 : S_DONE;
            done_q    <= ~stop2_q;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + DIV_W'(1);
          end
        end
        S_STOP2: begin
          tx_q <= 1'b1;
          if (cyc_last_d) begin
            cyc_cnt_q <= '0;
            state_q   <= S_DONE;
            done_q    <= 1'b1;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + DIV_W'(1);
          end
        end
        S_DONE: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          // Low time is at least one full frame, then extended for as long as tx_break is held.
          tx_q <= 1'b0;
          if (brk_cnt_q != frame_bits_d) begin
            if (cyc_last_d) begin
              cyc_cnt_q <= '0;
              brk_cnt_q <= brk_cnt_q + 4'd1;
            end else begin
              cyc_cnt_q <= cyc_cnt_q + DIV_W'(1);
            end
          end else if (!tx_break) begin
            tx_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
`endif
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != S_IDLE);
  assign tx_done = done_q;
  assign tx_err  = err_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed reset/error/abort cases plus randomized frames
// checked by a line monitor against an expected-frame queue.
module tb_uart_tx_frame;
  localparam int DIV_W = 17;
  localparam int EW    = DIV_W + 4 + 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tx_start = 1'b0;
  logic [7:0]       tx_data = '0;
  logic [3:0]       length = 4'd8;
  logic             parity_type = 1'b0;
  logic             parity_en = 1'b0;
  logic             stop2 = 1'b0;
  logic [DIV_W-1:0] baud = DIV_W'(4);
  logic             tx_break = 1'b0;
  logic             tx, tx_busy, tx_done, tx_err;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];

  uart_tx_frame #(.DIV_W(DIV_W), .MIN_DIV(2)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data), .length(length),
    .parity_type(parity_type), .parity_en(parity_en), .stop2(stop2), .baud(baud),
    .tx_break(tx_break), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the serial bit sequence of one frame, built from the frame rules.
  function automatic logic [EW-1:0] model(input logic [7:0] d, input int len, input bit pe,
                                          input bit pt, input bit s2, input int bd);
    logic [11:0] bits;
    int n;
    int ones;
    bits = '1;
    n = 0;
    ones = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < len; i++) begin
      bits[n] = d[i]; n++;
      ones += int'(d[i]);
    end
    if (pe) begin
      bits[n] = pt ? ((ones % 2) == 1) : ((ones % 2) == 0); n++;
    end
    bits[n] = 1'b1; n++;
    if (s2) begin bits[n] = 1'b1; n++; end
    return {DIV_W'(bd), 4'(n), bits};
  endfunction

  // monitor: follows each frame on the line and compares it with the queue head
  initial begin
    logic [EW-1:0] e;
    logic [11:0] bits;
    int n, bd;
    logic [2:0] act, first_bad;
    bit bad;
    forever begin
      @(negedge clk);
      if (mon_en && rst && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          bits = e[11:0];
          n = int'(e[15:12]);
          bd = int'(e[EW-1:16]);
          for (int b = 0; b < n; b++) begin
            bad = 1'b0;
            first_bad = {2'b10, bits[b]};
            for (int c = 0; c < bd; c++) begin
              if (b > 0 || c > 0) @(negedge clk);
              act = {tx_busy, tx_done, tx};
              if (!bad && act !== {2'b10, bits[b]}) begin
                bad = 1'b1;
                first_bad = act;
              end
            end
            check($sformatf("frame_bit%0d{busy,done,tx}", b), 32'(first_bad), 32'({2'b10, bits[b]}));
          end
          @(negedge clk);
          check("done_cycle{busy,done,tx}", 32'({tx_busy, tx_done, tx}), 32'b111);
          @(negedge clk);
          check("after_done{busy,done,tx}", 32'({tx_busy, tx_done, tx}), 32'b001);
        end
      end
    end
  end

  // driver tasks (inputs change 1 time unit after posedge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int len, input bit pe, input bit pt,
                      input bit s2, input int bd, input bit poke_done);
    bit seen;
    tx_data = d; length = 4'(len); parity_en = pe; parity_type = pt; stop2 = s2;
    baud = DIV_W'(bd); tx_start = 1'b1;
    exp_q.push_back(model(d, len, pe, pt, s2, bd));
    step();
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (tx_done) begin seen = 1'b1; break; end
      // Inputs change freely mid-frame; the shadowed frame must not notice.
      tx_data = 8'($urandom); length = 4'($urandom); parity_en = 1'($urandom);
      parity_type = 1'($urandom); stop2 = 1'($urandom); baud = DIV_W'($urandom_range(0, 9));
      tx_start = 1'($urandom);
      step();
    end
    if (!seen) check("frame_timeout", 32'd0, 32'd1);
    tx_start = 1'b0;
    if (poke_done) begin
      length = 4'd8; baud = DIV_W'(4); tx_start = 1'b1;
    end
    step();
    tx_start = 1'b0;
    if (poke_done) begin
      check("done_start_ignored_busy", 32'(tx_busy), 32'd0);
      step();
      check("done_start_ignored_busy2", 32'(tx_busy), 32'd0);
    end
  endtask

  task automatic bad_req(input int len, input int bd);
    length = 4'(len); baud = DIV_W'(bd); tx_data = 8'($urandom); tx_start = 1'b1;
    step();
    check($sformatf("err_pulse_len%0d_baud%0d{err,busy,tx}", len, bd),
          32'({tx_err, tx_busy, tx}), 32'b101);
    tx_start = 1'b0;
    step();
    check("err_clears{err,busy,tx}", 32'({tx_err, tx_busy, tx}), 32'b001);
  endtask

  initial begin
    // reset held while a legal request is present
    rst = 1'b0; tx_start = 1'b1; length = 4'd8; baud = DIV_W'(4);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_c%0d{tx,busy,done,err}", i),
            32'({tx, tx_busy, tx_done, tx_err}), 32'b1000);
    end
    tx_start = 1'b0; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_reset_idle_busy", 32'(tx_busy), 32'd0);
    end

    // rejected requests
    bad_req(9, 4);
    bad_req(4, 4);
    bad_req(8, 1);
    bad_req(5, 0);

    // reset during data bit 3 aborts the frame
    tx_data = 8'hA5; length = 4'd8; parity_en = 1'b1; stop2 = 1'b0; baud = DIV_W'(4);
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("abort_midframe_busy", 32'(tx_busy), 32'd1);
    rst = 1'b0;
    step();
    check("abort{tx,busy,done}", 32'({tx, tx_busy, tx_done}), 32'b100);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_quiet{tx,busy,done}", 32'({tx, tx_busy, tx_done}), 32'b100);
    end

    mon_en = 1'b1;
    send(8'hA5, 8, 1'b1, 1'b1, 1'b0, 4, 1'b0);
    send(8'hFF, 5, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    send(8'h00, 5, 1'b1, 1'b0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), $urandom_range(5, 8), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(2, 5), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) bad_req($urandom_range(0, 1) ? 3 : 12, 4);
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
    for (int i = 0; i < 4; i++) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
